// File: rtl/effect_cfg_if.sv
// Single-word config write bus: the sequencer drives a held request and the
// sink returns a one-cycle-or-longer accept.
interface effect_cfg_if;
    logic       cfg_valid;
    logic [2:0] cfg_addr;
    logic [4:0] cfg_data;
    logic       cfg_ack;

    modport master (output cfg_valid, output cfg_addr, output cfg_data, input cfg_ack);
    modport slave  (input cfg_valid, input cfg_addr, input cfg_data, output cfg_ack);
endinterface

// File: rtl/effect_cfg_sequencer.sv
// Pushes changed front-panel selections (effects, song, record mode) to the
// datapath register decoders; each burst starts only on an audio sample strobe.
module effect_cfg_sequencer #(
    parameter int ACK_TIMEOUT = 64,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [16:0]       effect_choice_sel,
    input  logic [3:0]        song_name_sel,
    input  logic              record_mode_sel,
    input  logic              ready,
    effect_cfg_if.master      cfg,
    output logic              busy,
    output logic              cfg_error,
    output logic [CNT_W-1:0]  cfg_writes
);

    localparam int NF = 7;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ARM, LOAD, SEND} state_t;

    state_t            state, state_next;
    logic [4:0]        field_in [NF];
    logic [4:0]        shadow   [NF];
    logic [NF-1:0]     dirty, dirty_next, changed, pending, clr, retry;
    logic [TW-1:0]     timer, timer_next;
    logic              valid_r, valid_next;
    logic [2:0]        addr_r, addr_next, sel;
    logic [4:0]        data_r, data_next;
    logic              error_next;
    logic [CNT_W-1:0]  writes_next;

    function automatic logic [2:0] lowest_set(input logic [NF-1:0] v);
        lowest_set = 3'd0;
        for (int i = NF - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = 3'(i);
        end
    endfunction

    // Every field is zero-extended to the 5-bit bus width so shadows compare uniformly.
    always_comb begin
        field_in[0] = effect_choice_sel[4:0];
        field_in[1] = effect_choice_sel[9:5];
        field_in[2] = {3'b000, effect_choice_sel[11:10]};
        field_in[3] = {3'b000, effect_choice_sel[13:12]};
        field_in[4] = {2'b00, effect_choice_sel[16:14]};
        field_in[5] = {1'b0, song_name_sel};
        field_in[6] = {4'b0000, record_mode_sel};
        for (int i = 0; i < NF; i++) begin
            changed[i] = (field_in[i] != shadow[i]);
        end
    end

    assign pending = dirty | changed;
    assign sel     = lowest_set(dirty);

    always_comb begin
        state_next  = state;
        timer_next  = timer;
        valid_next  = valid_r;
        addr_next   = addr_r;
        data_next   = data_r;
        error_next  = cfg_error;
        writes_next = cfg_writes;
        clr         = '0;
        retry       = '0;
        case (state)
            IDLE: if (|dirty) state_next = ARM;
            ARM:  if (ready) state_next = LOAD;
            LOAD: begin
                if (|dirty) begin
                    clr        = 7'b1 << sel;
                    addr_next  = sel;
                    data_next  = shadow[sel];
                    valid_next = 1'b1;
                    timer_next = '0;
                    state_next = SEND;
                end else begin
                    state_next = IDLE;
                end
            end
            SEND: begin
                if (cfg.cfg_ack) begin
                    valid_next  = 1'b0;
                    writes_next = cfg_writes + 1'b1;
                    state_next  = (|pending) ? LOAD : IDLE;
                end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
                    // Abandoned write is re-flagged so it retries on a later sample strobe.
                    valid_next = 1'b0;
                    error_next = 1'b1;
                    retry      = 7'b1 << addr_r;
                    state_next = IDLE;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // A fresh change outranks the load-clear on the same bit.
        dirty_next = (dirty & ~clr) | retry | changed;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            valid_r    <= 1'b0;
            addr_r     <= 3'd0;
            data_r     <= 5'd0;
            cfg_error  <= 1'b0;
            cfg_writes <= '0;
            dirty      <= '1;
            for (int i = 0; i < NF; i++) shadow[i] <= field_in[i];
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            valid_r    <= valid_next;
            addr_r     <= addr_next;
            data_r     <= data_next;
            cfg_error  <= error_next;
            cfg_writes <= writes_next;
            dirty      <= dirty_next;
            for (int i = 0; i < NF; i++) begin
                if (changed[i]) shadow[i] <= field_in[i];
            end
        end
    end

    assign cfg.cfg_valid = valid_r;
    assign cfg.cfg_addr  = addr_r;
    assign cfg.cfg_data  = data_r;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_effect_cfg_sequencer.sv
// Scoreboard bench: expected (addr,data) writes are queued as stimulus is driven
// and popped when the sink accepts a write.
module tb_effect_cfg_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [16:0] eff = '0;
    logic [3:0]  song = '0;
    logic        rec = 1'b1;
    logic        ready = 1'b0;
    logic        busy, cfg_error;
    logic [7:0]  cfg_writes;

    effect_cfg_if bus();

    effect_cfg_sequencer #(.ACK_TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .effect_choice_sel(eff), .song_name_sel(song),
        .record_mode_sel(rec), .ready(ready), .cfg(bus.master), .busy(busy),
        .cfg_error(cfg_error), .cfg_writes(cfg_writes)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];
    int exp_writes = 0;
    int ack_mode = 0;   // 0 tied high, 1 ack on 4th valid cycle, 2 never
    int hi_run = 0, lo_run = 0, last_gap = 0, last_hi = 0;
    logic [2:0] prev_addr = '0;
    logic [4:0] prev_data = '0;

    // Sink model and scoreboard
    initial begin
        logic ack;
        logic [7:0] e;
        bus.cfg_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.cfg_valid === 1'b1) begin
                hi_run++;
                if (hi_run == 1) last_gap = lo_run;
                lo_run = 0;
            end else begin
                if (hi_run > 0) last_hi = hi_run;
                hi_run = 0;
                lo_run++;
            end
            if (bus.cfg_valid === 1'b1 && hi_run > 1) begin
                n_checks++;
                if (bus.cfg_addr !== prev_addr || bus.cfg_data !== prev_data) begin
                    n_errors++;
                    $display("FAIL hold_stable: addr=%0d data=%0d, required addr=%0d data=%0d",
                             bus.cfg_addr, bus.cfg_data, prev_addr, prev_data);
                end
            end
            prev_addr = bus.cfg_addr;
            prev_data = bus.cfg_data;
            ack = (ack_mode == 0) ? 1'b1 :
                  (ack_mode == 1) ? (bus.cfg_valid === 1'b1 && hi_run == 4) : 1'b0;
            bus.cfg_ack = ack;
            if (bus.cfg_valid === 1'b1 && ack) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_write: addr=%0d data=%0d, required no write",
                             bus.cfg_addr, bus.cfg_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.cfg_addr, bus.cfg_data} !== e) begin
                        n_errors++;
                        $display("FAIL write: addr=%0d data=%0d, required addr=%0d data=%0d",
                                 bus.cfg_addr, bus.cfg_data, e[7:5], e[4:0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic pulse_ready();
        @(negedge clk) ready = 1'b1;
        @(negedge clk) ready = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && bus.cfg_valid === 1'b0) begin
                done = 1;
                break;
            end
        end
        #1;
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL %s_idle: busy=%0b, required 0 within 300 cycles", name, busy);
        end
    endtask

    task automatic wait_valid(input string name);
        bit done = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.cfg_valid === 1'b1) begin
                done = 1;
                break;
            end
        end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL %s_valid: cfg_valid=%0b, required 1 within 50 cycles", name, bus.cfg_valid);
        end
    endtask

    task automatic check_end(input string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s_pending: %0d writes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (cfg_writes !== 8'(exp_writes)) begin
            n_errors++;
            $display("FAIL %s_count: cfg_writes=%0d, required %0d", name, cfg_writes, exp_writes);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_busy: busy=%0b, required 0", name, busy);
        end
    endtask

    task automatic hold_without_ready(input string name);
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || bus.cfg_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_armed: busy=%0b valid=%0b, required busy=1 valid=0",
                     name, busy, bus.cfg_valid);
        end
    endtask

    task automatic push_full_config();
        exp_q.push_back({3'd0, eff[4:0]});
        exp_q.push_back({3'd1, eff[9:5]});
        exp_q.push_back({3'd2, 3'b000, eff[11:10]});
        exp_q.push_back({3'd3, 3'b000, eff[13:12]});
        exp_q.push_back({3'd4, 2'b00, eff[16:14]});
        exp_q.push_back({3'd5, 1'b0, song});
        exp_q.push_back({3'd6, 4'b0000, rec});
        exp_writes += 7;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.cfg_valid !== 1'b0 || bus.cfg_addr !== 3'd0 || bus.cfg_data !== 5'd0) begin
            n_errors++;
            $display("FAIL reset_bus: valid=%0b addr=%0d data=%0d, required 0 0 0",
                     bus.cfg_valid, bus.cfg_addr, bus.cfg_data);
        end
        n_checks++;
        if (busy !== 1'b0 || cfg_error !== 1'b0 || cfg_writes !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_status: busy=%0b err=%0b writes=%0d, required 0 0 0",
                     busy, cfg_error, cfg_writes);
        end
        reset = 1'b0;
    endtask

    task automatic test_flush();
        hold_without_ready("flush");
        push_full_config();
        pulse_ready();
        wait_idle("flush");
        check_end("flush");
        n_checks++;
        if (last_gap != 1) begin
            n_errors++;
            $display("FAIL flush_gap: gap=%0d, required 1", last_gap);
        end
    endtask

    task automatic test_single_change();
        @(negedge clk) eff[9:5] = 5'd17;
        hold_without_ready("single");
        n_checks++;
        if (cfg_writes !== 8'(exp_writes)) begin
            n_errors++;
            $display("FAIL single_early: cfg_writes=%0d, required %0d", cfg_writes, exp_writes);
        end
        exp_q.push_back({3'd1, 5'd17});
        exp_writes++;
        pulse_ready();
        wait_idle("single");
        check_end("single");
    endtask

    task automatic test_slow_sink();
        ack_mode = 1;
        @(negedge clk);
        eff[13:12] = 2'd2;
        song = 4'd11;
        hold_without_ready("slow");
        exp_q.push_back({3'd3, 5'd2});
        exp_q.push_back({3'd5, 5'd11});
        exp_writes += 2;
        pulse_ready();
        wait_idle("slow");
        check_end("slow");
        n_checks++;
        if (last_gap != 1 || last_hi != 4) begin
            n_errors++;
            $display("FAIL slow_timing: gap=%0d high=%0d, required gap=1 high=4", last_gap, last_hi);
        end
        ack_mode = 0;
    endtask

    task automatic test_timeout();
        bit fell = 0;
        ack_mode = 2;
        @(negedge clk) eff[16:14] = 3'd5;
        hold_without_ready("timeout");
        pulse_ready();
        wait_valid("timeout");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.cfg_valid === 1'b0) begin
                fell = 1;
                break;
            end
        end
        #1;
        n_checks++;
        if (!fell || last_hi != 4) begin
            n_errors++;
            $display("FAIL timeout_len: valid high %0d cycles, required 4", last_hi);
        end
        n_checks++;
        if (cfg_error !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_err: cfg_error=%0b, required 1", cfg_error);
        end
        hold_without_ready("timeout_retry");
        n_checks++;
        if (cfg_writes !== 8'(exp_writes)) begin
            n_errors++;
            $display("FAIL timeout_count: cfg_writes=%0d, required %0d", cfg_writes, exp_writes);
        end
        ack_mode = 0;
        exp_q.push_back({3'd4, 5'd5});
        exp_writes++;
        pulse_ready();
        wait_idle("timeout_retry");
        check_end("timeout_retry");
        n_checks++;
        if (cfg_error !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_sticky: cfg_error=%0b, required 1", cfg_error);
        end
    endtask

    task automatic test_change_in_send();
        ack_mode = 1;
        @(negedge clk) eff[4:0] = 5'd3;
        hold_without_ready("change");
        exp_q.push_back({3'd0, 5'd3});
        pulse_ready();
        wait_valid("change");
        eff[4:0] = 5'd9;
        exp_q.push_back({3'd0, 5'd9});
        exp_writes += 2;
        wait_idle("change");
        check_end("change");
        ack_mode = 0;
    endtask

    task automatic test_reset_in_send();
        ack_mode = 2;
        @(negedge clk) eff[11:10] = 2'd1;
        hold_without_ready("rst_send");
        pulse_ready();
        wait_valid("rst_send");
        reset = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.cfg_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_send_drop: valid=%0b busy=%0b, required 0 0", bus.cfg_valid, busy);
        end
        n_checks++;
        if (cfg_error !== 1'b0 || cfg_writes !== 8'd0) begin
            n_errors++;
            $display("FAIL rst_send_clear: err=%0b writes=%0d, required 0 0", cfg_error, cfg_writes);
        end
        reset = 1'b0;
        ack_mode = 0;
        exp_writes = 0;
        hold_without_ready("rst_flush");
        push_full_config();
        pulse_ready();
        wait_idle("rst_flush");
        check_end("rst_flush");
    endtask

    initial begin
        test_reset();
        test_flush();
        test_single_change();
        test_slow_sink();
        test_timeout();
        test_change_in_send();
        test_reset_in_send();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/effect_cfg_sequencer.md
Name: effect_cfg_sequencer

Overview:
- Pushes the user selections from the front-panel parameter selector to the audio datapath blocks over a single-word valid/ack config bus. Selections are song, record mode, and the echo/chorus/compression/limiter/distortion settings.
- Writes only the fields that changed. A burst of writes starts only on an audio sample strobe, so no effect changes mid-sample.
- Sits between the parameter selector and the effect chain / song player register decoders.

Parameters:
- ACK_TIMEOUT, 64: cycles cfg_valid may stay high without cfg_ack before the write is abandoned.
- CNT_W, 8: width of the accepted-write counter.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- effect_choice_sel  in  17  [4:0] echo, [9:5] chorus, [11:10] compression, [13:12] limiter, [16:14] distortion.
- song_name_sel  in  4  song index, 0-11.
- record_mode_sel  in  1  1 = record, 0 = play.
- ready  in  1  one-cycle audio sample strobe.
- cfg_valid  out  1  config write request.
- cfg_addr  out  3  field address: 0 echo, 1 chorus, 2 compression, 3 limiter, 4 distortion, 5 song, 6 record mode.
- cfg_data  out  5  field value, zero-extended to 5 bits.
- cfg_ack  in  1  sink accepts the write; counts only while cfg_valid=1.
- busy  out  1  high whenever state != IDLE.
- cfg_error  out  1  sticky flag: at least one write timed out.
- cfg_writes  out  CNT_W  count of acked writes; wraps modulo 2^CNT_W.

Behaviour:
- Reset (synchronous):
  - cfg_valid=0, cfg_addr=0, cfg_data=0, busy=0, cfg_error=0, cfg_writes=0, state=IDLE.
  - The 7 shadow registers load the current inputs.
  - dirty[6:0]=7'h7F, so the full configuration is written after reset.
  - Reset mid-write drops cfg_valid on the next edge and abandons the write; no ack is awaited.
- Change detect, every cycle:
  - For each field i, if the input value differs from shadow[i], shadow[i] takes the input value and dirty[i] is set.
  - If a set and a load-clear hit the same bit in the same cycle, the set wins.
- FSM states: IDLE, ARM, LOAD, SEND.
  - IDLE: if any dirty bit is set, go to ARM next cycle.
  - ARM: wait for ready=1. On that edge go to LOAD. ready pulses seen in any other state are ignored.
  - LOAD (1 cycle):
    - Select the lowest-index set dirty bit k and clear dirty[k].
    - Register cfg_addr=k and cfg_data=shadow[k].
    - Assert cfg_valid the next cycle and go to SEND.
    - If no dirty bit is set (not reachable in normal operation), return to IDLE.
  - SEND:
    - cfg_addr and cfg_data stay stable while cfg_valid=1.
    - A timeout counter starts at 0 on entry and increments each cycle without ack.
    - Ack: cfg_ack=1 on any cycle with cfg_valid=1, including the first, accepts the write. On the next edge cfg_valid=0 and cfg_writes increments. Go to LOAD if any dirty bit is set, else IDLE. Burst writes after the first do not wait for ready.
    - Timeout: with no ack on the ACK_TIMEOUT-th cycle of cfg_valid=1, clear cfg_valid on the next edge, set cfg_error, set dirty[k] again for retry, and go to IDLE. The retry therefore waits for a new ready.
  - Minimum spacing between consecutive writes is 1 idle cycle (the LOAD cycle).
- Input change while a field is in SEND: the in-flight data is not altered. The change detector re-sets dirty[k], so the field is rewritten later in the same burst with the new value.
- busy=1 in ARM, LOAD and SEND.

Test Plan:
- Post-reset flush: release reset with effect_choice_sel=17'h0, song=0, record=1, cfg_ack tied 1.
  - Required: after the first ready, exactly 7 writes in address order 0..6, with data 0,0,0,0,0,0,1.
  - cfg_writes=7 and busy=0 afterwards.
- Single field change: set effect_choice_sel[9:5]=5'd17 and hold ready low.
  - Required: no write until ready; then one write addr=1 data=17, and cfg_writes increments by 1.
- Multi-field change with slow sink: change limiter to 2 and song to 11; ack each write 3 cycles after cfg_valid rises.
  - Required: writes (3,2) then (5,11). addr/data stay stable across the wait, with a 1-cycle gap between writes.
- Timeout: ACK_TIMEOUT=4, change distortion to 5, cfg_ack held 0.
  - Required: cfg_valid high for 4 cycles then low; cfg_error=1 and stays 1.
  - At the next ready, addr=4 data=5 is reissued.
- Change during SEND: while the echo write (data=3) awaits ack, change echo to 9.
  - Required: data=3 completes, then addr=0 data=9 follows in the same burst.
- Reset during SEND: assert reset while cfg_valid=1.
  - Required: cfg_valid=0 next cycle, cfg_error and cfg_writes cleared, and the full 7-write flush occurs at the next ready.
